// File: rtl/itof_pipe.sv
// ============================================================================
//  Module   : itof_pipe
//  Purpose  : 3-stage valid/ready signed int32 -> IEEE-754 single converter
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module itof_pipe #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [7:0] c_exp_top = 8'd158;

    // stage registers
    logic             r_v1, r_v2, r_v3;
    logic             r_s1, r_s2;
    logic [31:0]      r_m1;
    logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
    logic             r_zero2;
    logic [31:0]      r_norm2;
    logic [7:0]       r_e2;
    logic [31:0]      r_res3;

    logic             w_adv1, w_adv2, w_adv3, w_en1;
    logic [4:0]       w_lz;
    logic [31:0]      w_norm1;
    logic [7:0]       w_e1;
    logic             w_rnd;
    logic [30:0]      w_mag;
    logic [31:0]      w_res2;

    // Ready flows backwards from the consumer only; it never depends on in_valid.
    assign w_adv3   = out_ready;
    assign w_adv2   = !r_v3 | w_adv3;
    assign w_adv1   = !r_v2 | w_adv2;
    assign w_en1    = !r_v1 | w_adv1;
    assign in_ready = !flush & w_en1;

    assign out_valid = r_v3;
    assign res       = r_res3;
    assign out_tag   = r_tag3;
    assign busy      = r_v1 | r_v2 | r_v3;

    always_comb begin
        w_lz = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (r_m1[i]) w_lz = 5'(31 - i);
        end
    end

    assign w_norm1 = r_m1 << w_lz;
    assign w_e1    = c_exp_top - {3'b000, w_lz};

    // Round-to-nearest-even; a carry out of the mantissa ripples into the exponent.
    assign w_rnd  = r_norm2[7] & ((|r_norm2[6:0]) | r_norm2[8]);
    assign w_mag  = {r_e2, r_norm2[30:8]} + {30'd0, w_rnd};
    assign w_res2 = r_zero2 ? 32'd0 : {r_s2, w_mag};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1   <= 1'b0;
            r_s1   <= 1'b0;
            r_m1   <= 32'd0;
            r_tag1 <= '0;
        end else if (flush) begin
            r_v1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1   <= x[31];
                r_m1   <= x[31] ? (~x + 32'd1) : x;
                r_tag1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v2    <= 1'b0;
            r_s2    <= 1'b0;
            r_zero2 <= 1'b0;
            r_norm2 <= 32'd0;
            r_e2    <= 8'd0;
            r_tag2  <= '0;
        end else if (flush) begin
            r_v2 <= 1'b0;
        end else if (w_adv1) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2    <= r_s1;
                r_zero2 <= (r_m1 == 32'd0);
                r_norm2 <= w_norm1;
                r_e2    <= w_e1;
                r_tag2  <= r_tag1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v3   <= 1'b0;
            r_res3 <= 32'd0;
            r_tag3 <= '0;
        end else if (flush) begin
            r_v3 <= 1'b0;
        end else if (w_adv2) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_res3 <= w_res2;
                r_tag3 <= r_tag2;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_itof_pipe.sv
// Testbench for itof_pipe: directed steps with a queue scoreboard and a
// remainder-based reference rounding model.
`default_nettype none

module tb_itof_pipe;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rstn, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0]      x, res;
    logic [TAG_W-1:0] in_tag, out_tag;

    logic [31:0]       exp_cur;
    logic [TAG_W+31:0] sbq[$];
    logic [TAG_W-1:0]  tag_ctr;
    bit                last_acc, rand_ready;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    itof_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_itof(input logic [31:0] xv);
        logic        s;
        logic [63:0] a, q, rem, half;
        int          p, sh;
        if (xv == 32'd0) return 32'd0;
        s = xv[31];
        a = s ? (64'h1_0000_0000 - {32'd0, xv}) : {32'd0, xv};
        p = 63;
        while (!a[p]) p--;
        if (p <= 23) begin
            q = a << (23 - p);
        end else begin
            sh   = p - 23;
            q    = a >> sh;
            rem  = a & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(p + 127), q[22:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // One clock: scoreboard bookkeeping at negedge, return 1 time unit after posedge.
    task automatic cyc();
        logic [TAG_W+31:0] e;
        @(negedge clk);
        last_acc = rstn && in_valid && in_ready;
        if (!rstn || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sbq.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected: observed res %h tag %h with empty scoreboard", res, out_tag);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sb_result", {26'd0, out_tag, res}, {26'd0, e});
                end
            end
            if (last_acc) sbq.push_back({in_tag, exp_cur});
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] xv, input logic [31:0] ev);
        int n;
        n        = 0;
        x        = xv;
        in_tag   = tag_ctr;
        exp_cur  = ev;
        in_valid = 1'b1;
        tag_ctr  = tag_ctr + 1'b1;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 200);
        checks++;
        assert (last_acc) else begin
            errors++;
            $error("FAIL accept_timeout: observed no accept of x=%h expected accept within 200 cycles", xv);
        end
    endtask

    task automatic drain();
        int n;
        n          = 0;
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while ((sbq.size() != 0 || busy) && n < 500) begin
            cyc();
            n++;
        end
        checks++;
        assert (sbq.size() == 0 && !busy) else begin
            errors++;
            $error("FAIL drain: observed %0d pending busy=%b expected 0 pending busy=0", sbq.size(), busy);
        end
    endtask

    initial begin
        logic [TAG_W-1:0] t;
        logic [31:0]      held, p, v;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 32'd0; in_tag = '0; exp_cur = 32'd0; tag_ctr = '0;
        rand_ready = 1'b0; last_acc = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rstn = 1'b1;

        // T1: zero and latency
        out_ready = 1'b1;
        t = tag_ctr;
        send(32'd0, 32'h0000_0000);
        in_valid = 1'b0;
        chk("t1_lat1", out_valid, 0);
        cyc();
        chk("t1_lat2", out_valid, 0);
        cyc();
        chk("t1_lat3", out_valid, 1);
        chk("t1_res", res, 32'h0000_0000);
        chk("t1_tag", out_tag, t);
        drain();

        // T2/T3: exact values and ties, streamed back to back
        send(32'd1,         32'h3F80_0000);
        send(32'hFFFF_FFFF, 32'hBF80_0000);
        send(32'h8000_0000, 32'hCF00_0000);
        send(32'h7FFF_FFFF, 32'h4F00_0000);
        send(32'd16777217,  32'h4B80_0000);
        send(32'd16777219,  32'h4B80_0002);
        send(-32'sd16777219, 32'hCB80_0002);
        drain();

        // T4: backpressure
        out_ready = 1'b0;
        send(32'd5, 32'h40A0_0000);
        send(32'd6, 32'h40C0_0000);
        send(-32'sd7, 32'hC0E0_0000);
        v = $urandom();
        x = v; in_tag = tag_ctr; exp_cur = ref_itof(v); in_valid = 1'b1;
        chk("t4_in_ready", in_ready, 0);
        chk("t4_busy", busy, 1);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_res_head", res, 32'h40A0_0000);
        held = res;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_res_stable", res, held);
            chk("t4_no_accept", sbq.size(), 3);
        end
        rand_ready = 1'b1;
        send(v, ref_itof(v));
        for (int i = 0; i < 19; i++) begin
            v = $urandom();
            send(v, ref_itof(v));
        end
        drain();

        // T5: flush kill
        out_ready = 1'b0;
        send(32'd1, 32'h3F80_0000);
        send(32'd2, 32'h4000_0000);
        send(32'd3, 32'h4040_0000);
        x = 32'd99; in_tag = tag_ctr; exp_cur = ref_itof(32'd99); in_valid = 1'b1;
        flush = 1'b1;
        chk("t5_flush_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_out_valid", out_valid, 0);
        chk("t5_flush_busy", busy, 0);
        cyc();
        chk("t5_flush_not_taken", busy, 0);
        out_ready = 1'b1;
        send(32'd1000, 32'h447A_0000);
        drain();

        // T5: asynchronous reset mid-cycle
        out_ready = 1'b0;
        send(-32'sd5, 32'hC0A0_0000);
        send(32'd7, 32'h40E0_0000);
        send(32'd9, 32'h4110_0000);
        in_valid = 1'b0;
        chk("t5_pre_rst_valid", out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_res", res, 0);
        chk("t5_rst_tag", out_tag, 0);
        chk("t5_rst_busy", busy, 0);
        cyc();
        rstn = 1'b1;
        out_ready = 1'b1;

        // T6: corner set and random operands with random stalls
        rand_ready = 1'b1;
        send(32'h8000_0000, ref_itof(32'h8000_0000));
        send(32'h7FFF_FFFF, ref_itof(32'h7FFF_FFFF));
        for (int k = 0; k < 31; k++) begin
            p = 32'd1 << k;
            send(p, ref_itof(p));
            send(-p, ref_itof(-p));
            send(p + 32'd1, ref_itof(p + 32'd1));
            send(p - 32'd1, ref_itof(p - 32'd1));
            send(-(p + 32'd1), ref_itof(-(p + 32'd1)));
            send(-(p - 32'd1), ref_itof(-(p - 32'd1)));
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cyc();
            end
            case ($urandom_range(0, 2))
                0:       v = $urandom();
                1:       v = $urandom() >> $urandom_range(0, 31);
                default: v = -($urandom() >> $urandom_range(0, 31));
            endcase
            send(v, ref_itof(v));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
